am_detect: RTL and testbench



---
 rtl/am_pkg.sv | 53 +++++
 rtl/seg7_hex_dec.sv | 40 ++++
 rtl/am_detect.sv | 166 ++++++++++++++++
 tb/tb_am_detect.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : am_pkg
//  Description : Shared types and constants for the amplitude-detect path:
//                FSM state enum, active-low 7-segment patterns, divisor range
//                and the quotient clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package am_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } am_state_t;

  // Range of the attenuation divisor k
  localparam logic [3:0] AM_CODE_MIN = 4'd1;
  localparam logic [3:0] AM_CODE_MAX = 4'd15;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Limit a raw 10-bit quotient to the legal divisor range
  function automatic logic [3:0] am_clamp(input logic [9:0] quot);
    logic [3:0] code;
    if (quot == 10'd0)
      code = AM_CODE_MIN;
    else if (quot > 10'(AM_CODE_MAX))
      code = AM_CODE_MAX;
    else
      code = quot[3:0];
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_dec.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_dec
//  Description : 4-bit hex digit to active-low 7-segment pattern {g..a}.
//                Purely combinational; the parent registers the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_dec
  import am_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Digit lookup
  always_comb begin
    seg = SEG_0;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/am_detect.sv
`default_nettype none
// ============================================================================
//  Module      : am_detect
//  Description : Measures peak-to-peak amplitude of a sample stream over a
//                fixed window and recovers the attenuation divisor
//                k = round(REF_PP / pp) with a 10-cycle restoring divider.
//                k is reported as a code and on an active-low 7-seg digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module am_detect
  import am_pkg::*;
#(
  parameter int WIN_LEN = 1024,
  parameter int REF_PP  = 255,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  output logic          busy,
  output logic [DW-1:0] pp_out,
  output logic [3:0]    am_code,
  output logic          code_valid,
  output logic [6:0]    seg_am
);

  localparam int            CW           = $clog2(WIN_LEN + 1);
  localparam logic [CW-1:0] C_LAST_CNT   = CW'(WIN_LEN - 1);
  // Rounded division: (2*REF + pp) / (2*pp) == round(REF / pp)
  localparam logic [9:0]    C_NUM_BASE   = 10'(2 * REF_PP);
  localparam logic [3:0]    C_LAST_STEP  = 4'd9;

  am_state_t     r_state;
  am_state_t     w_state_next;

  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_max;
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_pp;
  logic [3:0]    r_step;
  logic [8:0]    r_rem;
  logic [9:0]    r_quot;

  logic          w_accept;
  logic          w_win_done;
  logic [DW-1:0] w_max_new;
  logic [DW-1:0] w_min_new;
  logic [9:0]    w_num;
  logic [9:0]    w_den;
  logic [9:0]    w_rem_sh;
  logic          w_ge;
  logic [8:0]    w_rem_next;
  logic          w_div_last;
  logic [3:0]    w_code;
  logic [6:0]    w_seg;

  assign w_accept   = (r_state == ST_ACCUM) && sample_valid;
  assign w_win_done = w_accept && (r_cnt == C_LAST_CNT);

  // The first sample of a window seeds both extremes
  assign w_max_new = ((r_cnt == '0) || (sample > r_max)) ? sample : r_max;
  assign w_min_new = ((r_cnt == '0) || (sample < r_min)) ? sample : r_min;

  // Divider datapath: one numerator bit shifted in per cycle, MSB first.
  // The remainder is always below the denominator (<= 510), so 9 bits hold it.
  assign w_num      = C_NUM_BASE + 10'(r_pp);
  assign w_den      = {1'b0, r_pp[7:0], 1'b0};
  assign w_rem_sh   = {r_rem, w_num[C_LAST_STEP - r_step]};
  assign w_ge       = (w_rem_sh >= w_den);
  assign w_rem_next = w_ge ? 9'(w_rem_sh - w_den) : w_rem_sh[8:0];
  // pp==0 has no meaningful quotient and finishes in one cycle
  assign w_div_last = (r_pp == '0) || (r_step == C_LAST_STEP);

  assign w_code = am_clamp(r_quot);

  seg7_hex_dec u_seg_dec (
    .hex (w_code),
    .seg (w_seg)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_ACCUM;
    else
      r_state <= w_state_next;
  end

  // Next-state and busy decode
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (w_win_done)
          w_state_next = ST_DIVIDE;
      end
      ST_DIVIDE: begin
        busy = 1'b1;
        if (w_div_last)
          w_state_next = ST_DONE;
      end
      ST_DONE: begin
        busy         = 1'b1;
        w_state_next = ST_ACCUM;
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  // Window accumulation, divider iteration and output latching
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_max      <= '0;
      r_min      <= '0;
      r_pp       <= '0;
      r_step     <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      pp_out     <= '0;
      am_code    <= AM_CODE_MIN;
      code_valid <= 1'b0;
      seg_am     <= SEG_1;
    end else begin
      code_valid <= 1'b0;
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_max <= w_max_new;
            r_min <= w_min_new;
            if (w_win_done) begin
              // Closing sample is included; window restarts empty
              r_cnt  <= '0;
              r_pp   <= w_max_new - w_min_new;
              r_step <= '0;
              r_rem  <= '0;
              r_quot <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_DIVIDE: begin
          if (r_pp == '0) begin
            r_quot <= 10'(AM_CODE_MAX);
          end else begin
            r_step <= r_step + 4'd1;
            r_rem  <= w_rem_next;
            r_quot <= {r_quot[8:0], w_ge};
          end
        end
        ST_DONE: begin
          pp_out     <= r_pp;
          am_code    <= w_code;
          seg_am     <= w_seg;
          code_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_am_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_am_detect
//  Description : Self-checking bench for am_detect (WIN_LEN=16). A queue-based
//                reference model predicts every output each cycle; directed
//                scenarios add literal expectations and latency checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_am_detect;

  localparam int WIN_LEN = 16;
  localparam int REF_PP  = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = 8'd0;
  logic       busy;
  logic [7:0] pp_out;
  logic [3:0] am_code;
  logic       code_valid;
  logic [6:0] seg_am;

  int checks = 0;
  int errors = 0;

  am_detect #(
    .WIN_LEN (WIN_LEN),
    .REF_PP  (REF_PP),
    .DW      (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .busy         (busy),
    .pp_out       (pp_out),
    .am_code      (am_code),
    .code_valid   (code_valid),
    .seg_am       (seg_am)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // k = round(REF/pp) expressed with integer arithmetic, clamped to 1..15
  function automatic int model_code(input int pp);
    int q;
    if (pp == 0) return 15;
    q = (2 * REF_PP + pp) / (2 * pp);
    if (q < 1)  q = 1;
    if (q > 15) q = 15;
    return q;
  endfunction

  // Reference model: window as a queue, result published after a busy delay
  int   win_q[$];
  int   remaining;
  int   pend_pp, pend_code;
  int   m_pp, m_code;
  logic m_cv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q.delete();
      remaining = 0;
      pend_pp   = 0;
      pend_code = 1;
      m_pp      = 0;
      m_code    = 1;
      m_cv      = 1'b0;
    end else begin
      m_cv = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          m_pp   = pend_pp;
          m_code = pend_code;
          m_cv   = 1'b1;
        end
      end else if (sample_valid) begin
        win_q.push_back(int'(sample));
        if (win_q.size() == WIN_LEN) begin
          int mx, mn;
          mx = win_q[0];
          mn = win_q[0];
          foreach (win_q[i]) begin
            if (win_q[i] > mx) mx = win_q[i];
            if (win_q[i] < mn) mn = win_q[i];
          end
          pend_pp   = mx - mn;
          pend_code = model_code(pend_pp);
          remaining = (pend_pp == 0) ? 2 : 11;
          win_q.delete();
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of emitted codes
  int hist[$];
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",       int'(busy),       (remaining > 0) ? 1 : 0);
      check("code_valid", int'(code_valid), int'(m_cv));
      check("pp_out",     int'(pp_out),     m_pp);
      check("am_code",    int'(am_code),    m_code);
      check("seg_am",     int'(seg_am),     int'(seg_tab[m_code]));
      if (code_valid) hist.push_back(int'(am_code));
    end
  end

  // Inputs change 1 time unit after the rising edge
  task automatic send_sample(input int v);
    sample_valid = 1'b1;
    sample       = 8'(v);
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_alt(input int hi, input int lo);
    for (int i = 0; i < WIN_LEN; i++)
      send_sample((i % 2) ? hi : lo);
  endtask

  // Cycles from the last accepted sample to the code_valid pulse (bounded)
  task automatic wait_cv(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (code_valid) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("cv_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  int lat;
  int cv_count;
  int k_max  [6] = '{127, 85, 63, 51, 18, 17};
  int k_code [6] = '{2, 3, 4, 5, 14, 15};

  initial begin
    // Reset only
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_am_code", int'(am_code), 1);
    check("rst_seg_am",  int'(seg_am),  7'b1111001);
    check("rst_pp_out",  int'(pp_out),  0);
    check("rst_busy",    int'(busy),    0);
    check("rst_cv",      int'(code_valid), 0);
    @(posedge clk); #1;

    // Full-scale window
    send_alt(255, 0);
    wait_cv(lat);
    check("lat_full", lat, 12);
    check("full_pp",  int'(pp_out),  255);
    check("full_k",   int'(am_code), 1);

    // Attenuated windows
    for (int i = 0; i < 6; i++) begin
      send_alt(k_max[i], 0);
      wait_cv(lat);
      check("k_lat",  lat, 12);
      check("k_pp",   int'(pp_out),  k_max[i]);
      check("k_code", int'(am_code), k_code[i]);
      if (k_code[i] == 14) check("seg_E", int'(seg_am), 7'b0000110);
      if (k_code[i] == 15) check("seg_F", int'(seg_am), 7'b0001110);
    end

    // Flat signal: pp==0 shortcut
    for (int i = 0; i < WIN_LEN; i++) send_sample(8'h80);
    wait_cv(lat);
    check("lat_flat", lat, 3);
    check("flat_pp",  int'(pp_out),  0);
    check("flat_k",   int'(am_code), 15);

    // Valid held through busy: junk during busy must be dropped
    hist.delete();
    sample_valid = 1'b1;
    for (int i = 0; i < WIN_LEN; i++) begin
      sample = (i % 2) ? 8'd255 : 8'd0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 11; i++) begin
      sample = 8'd200;
      @(posedge clk); #1;
    end
    for (int i = 0; i < WIN_LEN; i++) begin
      sample = (i % 2) ? 8'd51 : 8'd0;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    wait_cv(lat);
    check("held_lat",   lat, 12);
    check("held_count", hist.size(), 2);
    if (hist.size() == 2) begin
      check("held_k0", hist[0], 1);
      check("held_k1", hist[1], 5);
    end
    check("held_pp", int'(pp_out), 51);

    // Reset during divide
    send_alt(255, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_am_code", int'(am_code), 1);
    check("abort_seg_am",  int'(seg_am),  7'b1111001);
    check("abort_pp_out",  int'(pp_out),  0);
    check("abort_busy",    int'(busy),    0);
    check("abort_cv",      int'(code_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cv_count = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (code_valid) cv_count++;
    end
    check("abort_no_cv", cv_count, 0);
    @(posedge clk); #1;
    send_alt(85, 0);
    wait_cv(lat);
    check("after_abort_lat", lat, 12);
    check("after_abort_pp",  int'(pp_out),  85);
    check("after_abort_k",   int'(am_code), 3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
